// File: rtl/nmr_bstrm_simp_ctrl.sv
// Sequencer for the simple bitstream datapath. Fetches {PLS_POL, mux_sel, data}
// entries from the sequence RAM, presents them to the datapath, prefetches the
// next entry while the current pulse plays, and times out the final entry.
module nmr_bstrm_simp_ctrl #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 10,
  parameter int MEM_LAT    = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  GO,
  input  logic                  ABORT,
  input  logic [ADDR_WIDTH:0]   N_ENTRIES,
  output logic                  MEM_RD,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  input  logic [DATA_WIDTH+4:0] MEM_RDDATA,
  output logic                  DP_RST,
  output logic                  DP_START,
  output logic [DATA_WIDTH-1:0] DP_DATA,
  output logic                  DP_PLS_POL,
  output logic [3:0]            DP_MUX_SEL,
  input  logic                  DP_RDY,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRIME, S_WRDY, S_STALL, S_ISSUE, S_TAIL, S_FIN
  } state_t;

  localparam logic [ADDR_WIDTH:0] MAX_ENT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] TWO     = (ADDR_WIDTH+1)'(2);

  state_t                  state;
  logic [ADDR_WIDTH:0]     n_ent;     // entries in this sequence (saturated)
  logic [ADDR_WIDTH:0]     rd_cnt;    // RAM reads issued so far
  logic [ADDR_WIDTH:0]     issued;    // entries placed on the DP_* lines so far
  logic [MEM_LAT-1:0]      vld_pipe;  // read-in-flight tracker, top bit = data valid now
  logic [DATA_WIDTH+4:0]   pf_buf;
  logic                    pf_valid;
  logic [DATA_WIDTH-1:0]   tail_cnt;

  logic [ADDR_WIDTH:0]     n_sat;
  logic                    arrive, pf_ready, more, can_rd;

  assign n_sat    = (N_ENTRIES > MAX_ENT) ? MAX_ENT : N_ENTRIES;
  assign arrive   = vld_pipe[MEM_LAT-1];
  // A word landing this very cycle counts as ready; it is captured on the same edge.
  assign pf_ready = pf_valid | arrive;
  assign more     = (issued < n_ent);
  assign can_rd   = (rd_cnt < n_ent);

  // Sequencer FSM, read tracking and all registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      n_ent      <= '0;
      rd_cnt     <= '0;
      issued     <= '0;
      vld_pipe   <= '0;
      pf_buf     <= '0;
      pf_valid   <= 1'b0;
      tail_cnt   <= '0;
      MEM_RD     <= 1'b0;
      MEM_ADDR   <= '0;
      DP_RST     <= 1'b1;
      DP_START   <= 1'b0;
      DP_DATA    <= '0;
      DP_PLS_POL <= 1'b0;
      DP_MUX_SEL <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      MEM_RD   <= 1'b0;
      DP_START <= 1'b0;
      vld_pipe <= MEM_LAT'({vld_pipe, MEM_RD});

      case (state)
        S_IDLE: begin
          if (GO) begin
            n_ent    <= n_sat;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            BUSY     <= 1'b1;
            rd_cnt   <= '0;
            issued   <= '0;
            pf_valid <= 1'b0;
            if (N_ENTRIES == '0) state <= S_FIN;
            else begin
              DP_RST <= 1'b0;
              state  <= S_PRIME;
            end
          end
        end
        // Read entry 0 (for the DP lines) and entry 1 (for the prefetch buffer);
        // leave once entry 0 has landed. The datapath's dummy period latches it.
        S_PRIME: begin
          if (rd_cnt < TWO && can_rd) begin
            MEM_RD   <= 1'b1;
            MEM_ADDR <= rd_cnt[ADDR_WIDTH-1:0];
            rd_cnt   <= rd_cnt + 1'b1;
          end
          if (arrive && issued == '0) state <= S_WRDY;
        end
        S_WRDY: begin
          if (DP_RDY) begin
            if (more) begin
              if (pf_ready) state <= S_ISSUE;
              else begin
                ERR   <= 1'b1;
                state <= S_STALL;
              end
            end else begin
              tail_cnt <= DP_DATA;
              state    <= S_TAIL;
            end
          end
        end
        S_STALL: begin
          if (pf_ready) state <= S_ISSUE;
        end
        // Present the prefetched entry with START and launch the next prefetch
        S_ISSUE: begin
          {DP_PLS_POL, DP_MUX_SEL, DP_DATA} <= pf_buf;
          DP_START <= 1'b1;
          pf_valid <= 1'b0;
          issued   <= issued + 1'b1;
          if (can_rd) begin
            MEM_RD   <= 1'b1;
            MEM_ADDR <= rd_cnt[ADDR_WIDTH-1:0];
            rd_cnt   <= rd_cnt + 1'b1;
          end
          state <= S_WRDY;
        end
        S_TAIL: begin
          if (tail_cnt <= DATA_WIDTH'(1)) state <= S_FIN;
          else tail_cnt <= tail_cnt - 1'b1;
        end
        S_FIN: begin
          DP_RST   <= 1'b1;
          DONE     <= 1'b1;
          BUSY     <= 1'b0;
          vld_pipe <= '0;
          pf_valid <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Route returning RAM words: the first goes straight to the DP lines,
      // later ones land in the prefetch buffer. At most one prefetch is in flight.
      if (arrive && state != S_IDLE && state != S_FIN) begin
        if (issued == '0) begin
          {DP_PLS_POL, DP_MUX_SEL, DP_DATA} <= MEM_RDDATA;
          issued <= (ADDR_WIDTH+1)'(1);
        end else begin
          pf_buf   <= MEM_RDDATA;
          pf_valid <= 1'b1;
        end
      end

      // Abort does the FIN work immediately so DP_RST and DONE follow on the
      // next cycle; any read in flight is dropped and ERR is left alone.
      if (ABORT && state != S_IDLE) begin
        state    <= S_IDLE;
        DP_RST   <= 1'b1;
        DONE     <= 1'b1;
        BUSY     <= 1'b0;
        MEM_RD   <= 1'b0;
        DP_START <= 1'b0;
        vld_pipe <= '0;
        pf_valid <= 1'b0;
      end
    end
  end

endmodule
